fixed_point_sm_accumulator: RTL and testbench
=============================================

Name: fixed_point_sm_accumulator

Overview:
- Downstream consumer of the sign-magnitude fixed-point subtractor: accumulates a frame of FRAME_LEN sign-magnitude Q-format difference samples into one saturating sign-magnitude total.
- Sits between the combinational subtractor and the result sink; valid/ready handshake on both sides.
- Data format matches the subtractor: bit N-1 is the sign (1 = negative), bits N-2:0 are the magnitude, and Q of those bits are fractional.

Parameters:
- Q, 15, fractional bits. Carried for format consistency only; the arithmetic does not depend on it.
- N, 32, total word width, sign included.
- FRAME_LEN, 8, samples per frame; must be >= 1.

Ports:
- clk, input, 1, system clock, rising edge.
- rst, input, 1, synchronous active-high reset.
- clr, input, 1, synchronous frame abort: clears the accumulator and sample count, drops out_valid.
- in_valid, input, 1, in_data is valid.
- in_ready, output, 1, block can accept a sample.
- in_data, input, N, sign-magnitude sample.
- out_valid, output, 1, frame total is valid.
- out_ready, input, 1, sink accepts the total.
- out_data, output, N, sign-magnitude frame total.
- out_sat, output, 1, saturation occurred at least once during this frame.

Behaviour:
- State machine has two states, ACCUM and DONE.
- Reset state is ACCUM, with acc = +0, count = 0, sat = 0.
- Output reset values: in_ready = 1, out_valid = 0, out_data = 0, out_sat = 0.
- Priority order: rst > clr > handshakes.
- ACCUM state:
  - in_ready = 1.
  - A sample is accepted on a cycle where in_valid & in_ready.
  - On accept, acc <= sm_add(acc, in_data) and count <= count + 1.
  - On the FRAME_LEN-th accept, move to DONE.
- Latency: last sample accepted at edge t; out_valid = 1 from edge t+1 on, with out_data/out_sat registered.
- DONE state:
  - in_ready = 0; in_valid is ignored and no sample is consumed.
  - out_valid = 1, and out_data/out_sat stay stable until out_valid & out_ready.
  - On that handshake: acc <= +0, count <= 0, sat <= 0, return to ACCUM, and in_ready = 1 from the next cycle.
  - No combinational path from out_ready to in_ready.
- clr:
  - In either state, next state is ACCUM with acc, count and sat cleared and out_valid = 0.
  - A sample presented in the same cycle as clr is dropped.
- sm_add(a, b), all on an N-bit magnitude path (one carry bit above the N-1 magnitude bits):
  - Same sign: magnitude = |a| + |b|; sign = the common sign.
  - Different signs: magnitude = larger - smaller; sign = sign of the larger magnitude. Equal magnitudes give +0.
  - Result magnitude 0 always encodes as +0. Inputs of -0 (sign 1, magnitude 0) are accepted and treated as 0.
  - Overflow (magnitude > 2^(N-1)-1): clamp the magnitude to 2^(N-1)-1, keep the sign, and set sat.
  - sat stays set for the rest of the frame; accumulation continues from the clamped value.
- Mid-operation behaviour:
  - count wraps to 0 only via the DONE handshake, clr or rst; there is no other wrap path.
  - rst in DONE discards the pending result: out_valid = 0 on the next cycle.

Decomposition:
- Shared package: format constants (N, Q), the MAX_MAG = 2^(N-1)-1 constant, sign-bit index, and the state enum {ACCUM, DONE}.
- One natural combinational sub-module: fixed_point_sm_add_sat.
  - Inputs: two N-bit sign-magnitude operands.
  - Outputs: N-bit saturated sum and an ovf flag.
  - Contains the whole sm_add function; it is reusable by the subtractor team.
- The top level holds the FSM, the counter and the registers.

Test Plan (FRAME_LEN = 4, N = 32, Q = 15; in_valid continuous, out_ready = 1 unless stated):
- Mixed-sign positive frame: 00008000, 00008000, 80004000, 00002000.
  - Required: out_data = 0000E000, out_sat = 0.
  - out_valid rises exactly 1 cycle after the 4th accept.
- Negative total: 80008000, 00002000, 80002000, 80004000.
  - Required: out_data = 8000C000, out_sat = 0.
- Cancellation and negative zero: 00004000, 80004000, 80000000, 00000000.
  - Required: out_data = 00000000, never 80000000.
- Saturation: 7FFFFFFF, 00000001, 80000001, 00000000.
  - Required: out_data = 7FFFFFFE, out_sat = 1.
  - Next frame of four 00000000 samples must give out_sat = 0.
- Backpressure: hold out_ready = 0 for 5 cycles after out_valid rises.
  - out_valid, out_data and out_sat stay stable; in_ready = 0; none of the offered samples are consumed.
  - Assert out_ready: in_ready = 1 on the following cycle, and the next frame starts from +0.
- Aborts:
  - clr after 2 accepts, then 4 × 00008000: out_data = 00020000.
  - rst while in DONE: out_valid = 0, in_ready = 1 and out_data = 0 on the next cycle.

Source files
------------

// File: rtl/fixed_point_sm_accumulator_pkg.sv
// rtl/fixed_point_sm_accumulator_pkg.sv - shared format constants and FSM state type
package fixed_point_sm_accumulator_pkg;

    // Sign-magnitude word format shared with the upstream subtractor
    localparam int SM_N        = 32;
    localparam int SM_Q        = 15;
    localparam int SM_SIGN_BIT = SM_N - 1;

    // Largest representable magnitude, 2^(N-1)-1
    localparam logic [SM_N-2:0] SM_MAX_MAG = '1;

    // Default frame length
    localparam int SM_FRAME_LEN = 8;

    typedef enum logic {
        ACCUM = 1'b0,
        DONE  = 1'b1
    } acc_state_t;

endpackage

// File: rtl/fixed_point_sm_accumulator_if.sv
// rtl/fixed_point_sm_accumulator_if.sv - sample input and frame-total output handshakes
interface fixed_point_sm_accumulator_if
    import fixed_point_sm_accumulator_pkg::*;
#(
    parameter int N = SM_N
);

    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] in_data;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] out_data;
    logic         out_sat;

    // Source of samples and sink of totals
    modport master (
        output in_valid,
        output in_data,
        input  in_ready,
        input  out_valid,
        input  out_data,
        input  out_sat,
        output out_ready
    );

    // The accumulator itself
    modport slave (
        input  in_valid,
        input  in_data,
        output in_ready,
        output out_valid,
        output out_data,
        output out_sat,
        input  out_ready
    );

endinterface

// File: rtl/fixed_point_sm_accumulator_add_sat.sv
// rtl/fixed_point_sm_accumulator_add_sat.sv - saturating sign-magnitude adder
module fixed_point_sm_add_sat
    import fixed_point_sm_accumulator_pkg::*;
#(
    parameter int N = SM_N
) (
    input  logic [N-1:0] a_i,
    input  logic [N-1:0] b_i,
    output logic [N-1:0] sum_o,
    output logic         ovf_o
);

    localparam logic [N-2:0] MAG_MAX = '1;

    logic         sign_a;
    logic         sign_b;
    logic [N-2:0] mag_a;
    logic [N-2:0] mag_b;
    logic [N-1:0] mag_sum;
    logic [N-2:0] mag_r;
    logic         sign_r;

    assign sign_a = a_i[N-1];
    assign sign_b = b_i[N-1];
    assign mag_a  = a_i[N-2:0];
    assign mag_b  = b_i[N-2:0];

    // Add like signs with a carry bit, subtract unlike signs smaller-from-larger
    always_comb begin
        mag_sum = '0;
        mag_r   = '0;
        sign_r  = 1'b0;
        ovf_o   = 1'b0;
        if (sign_a == sign_b) begin
            mag_sum = {1'b0, mag_a} + {1'b0, mag_b};
            sign_r  = sign_a;
            if (mag_sum[N-1]) begin
                ovf_o = 1'b1;
                mag_r = MAG_MAX;
            end else begin
                mag_r = mag_sum[N-2:0];
            end
        end else if (mag_a >= mag_b) begin
            mag_r  = mag_a - mag_b;
            sign_r = sign_a;
        end else begin
            mag_r  = mag_b - mag_a;
            sign_r = sign_b;
        end
        // A zero magnitude is always emitted as +0, whatever the operand signs
        sum_o = {sign_r & (mag_r != '0), mag_r};
    end

endmodule

// File: rtl/fixed_point_sm_accumulator.sv
// rtl/fixed_point_sm_accumulator.sv - frame accumulator of sign-magnitude samples
module fixed_point_sm_accumulator
    import fixed_point_sm_accumulator_pkg::*;
#(
    parameter int Q         = SM_Q,
    parameter int N         = SM_N,
    parameter int FRAME_LEN = SM_FRAME_LEN
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             clr,
    fixed_point_sm_accumulator_if.slave      bus
);

    localparam int             CW   = $clog2(FRAME_LEN + 1);
    localparam logic [CW-1:0]  LAST = CW'(FRAME_LEN - 1);

    // Reject parameter sets the format cannot represent
    if (FRAME_LEN < 1) begin : g_bad_frame
        $error("FRAME_LEN must be at least 1");
    end
    if (Q < 0 || Q > N - 1) begin : g_bad_q
        $error("Q must fit within the magnitude bits");
    end

    acc_state_t    state_q;
    logic [N-1:0]  acc_q;
    logic [CW-1:0] count_q;
    logic          sat_q;
    logic          in_ready_q;
    logic          out_valid_q;
    logic [N-1:0]  out_data_q;
    logic          out_sat_q;

    logic [N-1:0]  acc_d;
    logic [CW-1:0] count_d;
    logic          sat_d;
    logic          add_ovf;
    logic          accept;

    fixed_point_sm_add_sat #(
        .N (N)
    ) u_add (
        .a_i   (acc_q),
        .b_i   (bus.in_data),
        .sum_o (acc_d),
        .ovf_o (add_ovf)
    );

    assign accept  = bus.in_valid & in_ready_q;
    assign count_d = count_q + CW'(1);
    assign sat_d   = sat_q | add_ovf;

    // Frame FSM: accumulate FRAME_LEN samples, then hold the total until taken
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ACCUM;
            acc_q       <= '0;
            count_q     <= '0;
            sat_q       <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_sat_q   <= 1'b0;
        end else if (clr) begin
            state_q     <= ACCUM;
            acc_q       <= '0;
            count_q     <= '0;
            sat_q       <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                ACCUM: begin
                    if (accept) begin
                        acc_q   <= acc_d;
                        count_q <= count_d;
                        sat_q   <= sat_d;
                        if (count_q == LAST) begin
                            state_q     <= DONE;
                            in_ready_q  <= 1'b0;
                            out_valid_q <= 1'b1;
                            out_data_q  <= acc_d;
                            out_sat_q   <= sat_d;
                        end
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        state_q     <= ACCUM;
                        acc_q       <= '0;
                        count_q     <= '0;
                        sat_q       <= 1'b0;
                        in_ready_q  <= 1'b1;
                        out_valid_q <= 1'b0;
                    end
                end
                default: begin
                    state_q <= ACCUM;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_sat   = out_sat_q;

endmodule

// File: tb/tb_fixed_point_sm_accumulator.sv
// tb/tb_fixed_point_sm_accumulator.sv - directed self-checking bench for the frame accumulator
module tb_fixed_point_sm_accumulator;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic clr = 1'b0;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    fixed_point_sm_accumulator_if #(.N(32)) bus ();

    fixed_point_sm_accumulator #(
        .Q         (15),
        .N         (32),
        .FRAME_LEN (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .clr (clr),
        .bus (bus)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Offer four samples back to back; sample k is driven on the negedge before its accept edge
    task automatic feed4(input string tag, input logic [31:0] s0, input logic [31:0] s1,
                         input logic [31:0] s2, input logic [31:0] s3);
        logic [31:0] v [4];
        v[0] = s0; v[1] = s1; v[2] = s2; v[3] = s3;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check({tag, "_in_ready"}, {31'd0, bus.in_ready}, 32'd1);
            if (i == 3) check({tag, "_no_early_valid"}, {31'd0, bus.out_valid}, 32'd0);
            bus.in_valid = 1'b1;
            bus.in_data  = v[i];
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.in_data  = 32'h0;
    endtask

    // Expect the total one cycle after the 4th accept, then let the default out_ready take it
    task automatic expect_total(input string tag, input logic [31:0] data, input logic sat);
        check({tag, "_out_valid"}, {31'd0, bus.out_valid}, 32'd1);
        check({tag, "_out_data"}, bus.out_data, data);
        check({tag, "_out_sat"}, {31'd0, bus.out_sat}, {31'd0, sat});
        check({tag, "_in_ready_done"}, {31'd0, bus.in_ready}, 32'd0);
        @(negedge clk);
        check({tag, "_released"}, {31'd0, bus.out_valid}, 32'd0);
        check({tag, "_in_ready_back"}, {31'd0, bus.in_ready}, 32'd1);
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_data   = 32'h0;
        bus.out_ready = 1'b1;

        repeat (2) @(negedge clk);
        check("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
        check("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        check("rst_out_data", bus.out_data, 32'h0);
        check("rst_out_sat", {31'd0, bus.out_sat}, 32'd0);
        rst = 1'b0;

        feed4("mixed", 32'h00008000, 32'h00008000, 32'h80004000, 32'h00002000);
        expect_total("mixed", 32'h0000E000, 1'b0);

        feed4("neg", 32'h80008000, 32'h00002000, 32'h80002000, 32'h80004000);
        expect_total("neg", 32'h8000C000, 1'b0);

        feed4("cancel", 32'h00004000, 32'h80004000, 32'h80000000, 32'h00000000);
        expect_total("cancel", 32'h00000000, 1'b0);

        feed4("sat", 32'h7FFFFFFF, 32'h00000001, 32'h80000001, 32'h00000000);
        expect_total("sat", 32'h7FFFFFFE, 1'b1);

        feed4("after_sat", 32'h0, 32'h0, 32'h0, 32'h0);
        expect_total("after_sat", 32'h00000000, 1'b0);

        // Backpressure: total held while the sink stalls, offered samples ignored
        bus.out_ready = 1'b0;
        feed4("bp", 32'h00008000, 32'h00008000, 32'h80004000, 32'h00002000);
        bus.in_valid = 1'b1;
        bus.in_data  = 32'h00100000;
        for (int c = 0; c < 5; c++) begin
            check("bp_hold_valid", {31'd0, bus.out_valid}, 32'd1);
            check("bp_hold_data", bus.out_data, 32'h0000E000);
            check("bp_hold_sat", {31'd0, bus.out_sat}, 32'd0);
            check("bp_hold_in_ready", {31'd0, bus.in_ready}, 32'd0);
            @(negedge clk);
        end
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_data   = 32'h0;
        @(negedge clk);
        check("bp_release_valid", {31'd0, bus.out_valid}, 32'd0);
        check("bp_release_in_ready", {31'd0, bus.in_ready}, 32'd1);
        feed4("bp_next", 32'h00001000, 32'h00001000, 32'h00001000, 32'h00001000);
        expect_total("bp_next", 32'h00004000, 1'b0);

        // Abort after two accepts; the sample alongside clr is dropped
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_data  = 32'h00040000;
        @(negedge clk);
        bus.in_data  = 32'h80010000;
        @(negedge clk);
        clr          = 1'b1;
        bus.in_data  = 32'h00100000;
        @(negedge clk);
        clr          = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data  = 32'h0;
        check("clr_out_valid", {31'd0, bus.out_valid}, 32'd0);
        check("clr_in_ready", {31'd0, bus.in_ready}, 32'd1);
        feed4("clr_next", 32'h00008000, 32'h00008000, 32'h00008000, 32'h00008000);
        expect_total("clr_next", 32'h00020000, 1'b0);

        // Reset while a total is pending discards it
        bus.out_ready = 1'b0;
        feed4("rst_done", 32'h00008000, 32'h00008000, 32'h00008000, 32'h00008000);
        check("rst_done_pending", {31'd0, bus.out_valid}, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst_done_out_valid", {31'd0, bus.out_valid}, 32'd0);
        check("rst_done_in_ready", {31'd0, bus.in_ready}, 32'd1);
        check("rst_done_out_data", bus.out_data, 32'h0);
        bus.out_ready = 1'b1;

        // Fresh frame after the reset starts from +0
        feed4("post_rst", 32'h80001000, 32'h80001000, 32'h00000000, 32'h80000000);
        expect_total("post_rst", 32'h80002000, 1'b0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
